response_demux: RTL and testbench
=================================

Name: response_demux

Overview:
- Return-path counterpart of the ID table.
- Accepts read/write response beats from the memory side, looks up each burst's transaction ID in the ID table to find the originating port, and steers all beats of that burst to that port.
- On the accepted last beat it invalidates the table entry.
- Responses whose ID is not in the table are drained and counted as orphans.
- Sits between the memory-side response channel and the per-port slave response channels in MemorEDF.

Parameters:
- NUMBER_OF_PORTS, 2, number of requesting ports.
- ID_WIDTH, 16, transaction ID width.
- DATA_WIDTH, 128, response data width.
- PORT_WIDTH (localparam), max(1, $clog2(NUMBER_OF_PORTS)), width of a port index.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_id  in  ID_WIDTH  response ID from memory side.
- s_data  in  DATA_WIDTH  response data beat.
- s_last  in  1  final beat of burst.
- s_valid  in  1  beat valid.
- s_ready  out  1  beat accepted when s_valid && s_ready.
- m_data  out  DATA_WIDTH  s_data passed through (shared by all ports).
- m_last  out  1  s_last passed through.
- m_valid  out  NUMBER_OF_PORTS  one-hot valid toward the target port.
- m_ready  in  NUMBER_OF_PORTS  per-port ready.
- table_id  out  ID_WIDTH  ID presented to the ID table (registered cur_id).
- table_lookup  out  1  one-cycle lookup request.
- table_invalidate  out  1  one-cycle invalidate request.
- table_answer  in  PORT_WIDTH  origin port; valid the cycle after table_lookup.
- table_hit  in  1  hit flag; valid the cycle after table_lookup.
- orphan  out  1  one-cycle pulse when a miss is resolved.
- orphan_count  out  16  saturating count of orphan bursts.

Behaviour:
- Reset values: state IDLE; cur_id 0; cur_port 0; s_ready 0; m_valid 0; table_lookup 0; table_invalidate 0; orphan 0; orphan_count 0. Reset is asynchronous and may land mid-burst; the remaining beats of that burst are then treated as a new burst and looked up afresh.
- FSM states: IDLE, LOOKUP, RESOLVE, ROUTE, DROP.
- IDLE: s_ready=0. When s_valid=1, latch cur_id<=s_id and go to LOOKUP.
- LOOKUP: table_lookup=1 for exactly one cycle with table_id=cur_id; go to RESOLVE.
- RESOLVE: sample table_hit and table_answer.
  - Hit with table_answer<NUMBER_OF_PORTS: cur_port<=table_answer; go to ROUTE.
  - Otherwise (miss, or answer out of range): orphan=1 for one cycle; orphan_count increments, saturating at 16'hFFFF; go to DROP.
- ROUTE: combinational pass-through.
  - m_valid[cur_port]=s_valid; all other m_valid bits 0.
  - s_ready=m_ready[cur_port]; m_data=s_data; m_last=s_last.
  - On a handshake with s_last=1: table_invalidate=1 in that same cycle with table_id=cur_id; go to IDLE.
- DROP: s_ready=1 and m_valid=0. Consume beats until a handshake with s_last=1, then go to IDLE. No invalidate is issued.
- Latency: s_valid seen in IDLE at cycle 0 → table_lookup at cycle 1 → resolve at cycle 2 → first beat offered on m_valid at cycle 3. Subsequent beats have 1-cycle throughput, gated only by m_ready.
- A single-beat burst (s_last=1 on the first beat) completes in ROUTE in one handshake.
- One idle cycle separates bursts (ROUTE→IDLE). table_lookup and table_invalidate are never asserted in the same cycle.
- Protocol rule: s_id must be constant across beats of a burst. A simulation assertion flags s_id!=cur_id on any handshake in ROUTE/DROP.
- s_data/s_last/s_id are not registered; the upstream holds them stable while s_valid && !s_ready.

Decomposition:
- Shared package memoredf_pkg holds:
  - typedef enum logic [2:0] demux_state_t {IDLE, LOOKUP, RESOLVE, ROUTE, DROP};
  - function port_width(n), returning max(1, $clog2(n)).
- One sub-module: sat_counter (parameter WIDTH=16; inputs clock, reset, inc; output count, saturating). Instantiated for orphan_count.

Test Plan:
- The bench instantiates response_demux together with a real ID table (NUMBER_OF_PORTS=2, ID_WIDTH=16, 32 entries).
- Insert 0x01ad origin 1; send one beat id 0x01ad data 0xAA..AA last=1, m_ready=2'b11 → m_valid=2'b10 exactly 3 cycles after s_valid; m_data=0xAA..AA; table_invalidate pulses once with table_id=0x01ad; a later lookup of 0x01ad misses.
- Insert 0x018d origin 0; 4-beat burst with m_ready[0] pattern 1,0,1,0,1,0,1 → all 4 beats delivered in order on port 0; s_ready mirrors m_ready[0]; m_valid[1] stays 0; a single invalidate on beat 4.
- 3-beat burst id 0x090d (never inserted) → orphan pulses once in RESOLVE; s_ready=1 for 3 beats; m_valid=0 throughout; orphan_count=1; no table_invalidate.
- Insert 0x01ad→port 1 and 0x01cd→port 0; back-to-back 2-beat bursts → the second burst's table_lookup occurs 2 cycles after the first burst's last handshake; the beats go to port 1 then port 0; two invalidates are issued.
- Assert reset asynchronously after beat 2 of a 4-beat burst → s_ready, m_valid and orphan_count read 0 before the next edge; after release, beat 3 triggers a new lookup (table_lookup=1, table_id=burst ID).

Source files
------------

// File: rtl/memoredf_pkg.sv
// Shared types and helpers for the MemorEDF response path.
package memoredf_pkg;

   typedef enum logic [2:0] {IDLE, LOOKUP, RESOLVE, ROUTE, DROP} demux_state_t;

   function automatic int port_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/response_demux_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) count_d = count_q + WIDTH'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/response_demux.sv
// Steers memory-side response bursts to the port that issued them, using the
// ID table to recover the origin; unknown IDs are drained and counted.
module response_demux
   import memoredf_pkg::*;
#(
   parameter  int NUMBER_OF_PORTS = 2,
   parameter  int ID_WIDTH        = 16,
   parameter  int DATA_WIDTH      = 128,
   localparam int PORT_WIDTH      = port_width(NUMBER_OF_PORTS)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [ID_WIDTH-1:0]        s_id,
   input  logic [DATA_WIDTH-1:0]      s_data,
   input  logic                       s_last,
   input  logic                       s_valid,
   output logic                       s_ready,
   output logic [DATA_WIDTH-1:0]      m_data,
   output logic                       m_last,
   output logic [NUMBER_OF_PORTS-1:0] m_valid,
   input  logic [NUMBER_OF_PORTS-1:0] m_ready,
   output logic [ID_WIDTH-1:0]        table_id,
   output logic                       table_lookup,
   output logic                       table_invalidate,
   input  logic [PORT_WIDTH-1:0]      table_answer,
   input  logic                       table_hit,
   output logic                       orphan,
   output logic [15:0]                orphan_count,
   output demux_state_t               dbg_state
);

   // Handshake: a beat moves on a rising edge where s_valid && s_ready; the
   // upstream holds s_id/s_data/s_last stable while s_valid && !s_ready.
   demux_state_t          state_q, state_d;
   logic [ID_WIDTH-1:0]   cur_id_q, cur_id_d;
   logic [PORT_WIDTH-1:0] cur_port_q, cur_port_d;

   always_comb begin
      state_d          = state_q;
      cur_id_d         = cur_id_q;
      cur_port_d       = cur_port_q;
      s_ready          = 1'b0;
      m_valid          = '0;
      table_lookup     = 1'b0;
      table_invalidate = 1'b0;
      orphan           = 1'b0;
      case (state_q)
         IDLE: begin
            if (s_valid) begin
               cur_id_d = s_id;
               state_d  = LOOKUP;
            end
         end
         LOOKUP: begin
            table_lookup = 1'b1;
            state_d      = RESOLVE;
         end
         RESOLVE: begin
            // An out-of-range answer is as useless as a miss, so drain it too.
            if (table_hit && (int'(table_answer) < NUMBER_OF_PORTS)) begin
               cur_port_d = table_answer;
               state_d    = ROUTE;
            end else begin
               orphan  = 1'b1;
               state_d = DROP;
            end
         end
         ROUTE: begin
            m_valid[cur_port_q] = s_valid;
            s_ready             = m_ready[cur_port_q];
            if (s_valid && s_ready && s_last) begin
               table_invalidate = 1'b1;
               state_d          = IDLE;
            end
         end
         DROP: begin
            s_ready = 1'b1;
            if (s_valid && s_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cur_id_q   <= '0;
         cur_port_q <= '0;
      end else begin
         state_q    <= state_d;
         cur_id_q   <= cur_id_d;
         cur_port_q <= cur_port_d;
      end
   end

   assign m_data    = s_data;
   assign m_last    = s_last;
   assign table_id  = cur_id_q;
   assign dbg_state = state_q;

   sat_counter #(.WIDTH(16)) u_orphan_count (
      .clock (clock),
      .reset (reset),
      .inc   (orphan),
      .count (orphan_count)
   );

   a_id_stable: assert property (@(posedge clock) disable iff (reset)
      (((state_q == ROUTE) || (state_q == DROP)) && s_valid && s_ready) |-> (s_id == cur_id_q));

endmodule

// File: tb/tb_response_demux.sv
// Bench for response_demux with a behavioural 32-entry ID table and a
// scoreboard of expected beats per port.
module tb_response_demux;
   import memoredf_pkg::*;

   localparam int NP   = 2;
   localparam int IDW  = 16;
   localparam int DW   = 128;
   localparam int PW   = 1;
   localparam int TBL  = 32;
   localparam int EXPW = PW + 1 + DW;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [IDW-1:0] s_id = '0;
   logic [DW-1:0]  s_data = '0;
   logic           s_last = 1'b0;
   logic           s_valid = 1'b0;
   logic           s_ready;
   logic [DW-1:0]  m_data;
   logic           m_last;
   logic [NP-1:0]  m_valid;
   logic [NP-1:0]  m_ready = '1;
   logic [IDW-1:0] table_id;
   logic           table_lookup, table_invalidate;
   logic [PW-1:0]  table_answer;
   logic           table_hit;
   logic           orphan;
   logic [15:0]    orphan_count;
   demux_state_t   dbg_state;

   always #5 clock = ~clock;

   response_demux #(.NUMBER_OF_PORTS(NP), .ID_WIDTH(IDW), .DATA_WIDTH(DW)) dut (
      .clock(clock), .reset(reset), .s_id(s_id), .s_data(s_data), .s_last(s_last),
      .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_last(m_last),
      .m_valid(m_valid), .m_ready(m_ready), .table_id(table_id),
      .table_lookup(table_lookup), .table_invalidate(table_invalidate),
      .table_answer(table_answer), .table_hit(table_hit), .orphan(orphan),
      .orphan_count(orphan_count), .dbg_state(dbg_state)
   );

   // ---------------- ID table model ----------------
   logic           tbl_v[TBL] = '{default: 1'b0};
   logic [IDW-1:0] tbl_id[TBL];
   logic [PW-1:0]  tbl_port[TBL];
   logic           ins_req = 1'b0;
   logic [IDW-1:0] ins_id = '0;
   logic [PW-1:0]  ins_port = '0;
   logic           tbl_hit_q = 1'b0;
   logic [PW-1:0]  tbl_ans_q = '0;

   always @(posedge clock) begin
      int free;
      free = -1;
      if (ins_req) begin
         for (int i = TBL - 1; i >= 0; i--) if (!tbl_v[i]) free = i;
         if (free >= 0) begin
            tbl_v[free]    <= 1'b1;
            tbl_id[free]   <= ins_id;
            tbl_port[free] <= ins_port;
         end
      end
      if (table_lookup) begin
         tbl_hit_q <= 1'b0;
         for (int i = 0; i < TBL; i++)
            if (tbl_v[i] && tbl_id[i] == table_id) begin
               tbl_hit_q <= 1'b1;
               tbl_ans_q <= tbl_port[i];
            end
      end
      if (table_invalidate)
         for (int i = 0; i < TBL; i++)
            if (tbl_v[i] && tbl_id[i] == table_id) tbl_v[i] <= 1'b0;
   end

   assign table_hit    = tbl_hit_q;
   assign table_answer = tbl_ans_q;

   function automatic logic table_has(input logic [IDW-1:0] id);
      for (int i = 0; i < TBL; i++) if (tbl_v[i] && tbl_id[i] == id) return 1'b1;
      return 1'b0;
   endfunction

   // ---------------- scoreboard state ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [EXPW-1:0] exp_q[$];
   logic [IDW-1:0]  inv_q[$];
   int ref_map[logic [IDW-1:0]];
   int exp_inv = 0, exp_orph = 0, exp_orph_tot = 0;

   int cyc = 0;
   int first_mv_cyc = 0, burst_start_cyc = 0, last_hs_cyc = 0, lookup_gap = 0;
   int inv_cnt = 0, orphan_pulses = 0, drop_hs = 0, mv1_cnt = 0, lookup_cnt = 0;
   logic [IDW-1:0] lookup_id = '0;
   logic mv_prev = 1'b0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input string msg);
      n_cmp++;
      n_err++;
      $display("FAIL %s: %s", name, msg);
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // ---------------- sink ready generator ----------------
   int   rdy_mode = 0;
   logic tog = 1'b1;
   always @(posedge clock) begin
      #1;
      case (rdy_mode)
         1:       begin m_ready = {1'b1, tog}; tog = ~tog; end
         2:       m_ready = NP'($urandom_range(0, (1 << NP) - 1));
         default: m_ready = '1;
      endcase
   end

   // ---------------- monitor ----------------
   always @(negedge clock) begin
      logic [EXPW-1:0] e;
      int p;
      if (!reset) begin
         if (table_lookup && table_invalidate) fail("lookup_inv_overlap", "both asserted");
         if (m_valid != '0) begin
            check("m_valid_onehot", $countones(m_valid), 1);
            check("s_ready_mirror", s_ready, |(m_valid & m_ready));
            if (!mv_prev) first_mv_cyc = cyc;
         end
         mv_prev = (m_valid != '0);
         if (m_valid[1]) mv1_cnt++;
         if (|(m_valid & m_ready)) begin
            p = 0;
            for (int i = 0; i < NP; i++) if (m_valid[i]) p = i;
            if (exp_q.size() == 0) fail("sb_unexpected_beat", $sformatf("port %0d data %0h", p, m_data));
            else begin
               e = exp_q.pop_front();
               check("sb_port", p, e[EXPW-1 -: PW]);
               check("sb_last", m_last, e[DW]);
               check("sb_data", m_data, e[DW-1:0]);
            end
         end
         if (s_valid && s_ready && m_valid == '0) drop_hs++;
         if (s_valid && s_ready && s_last) last_hs_cyc = cyc;
         if (orphan) orphan_pulses++;
         if (table_lookup) begin
            lookup_cnt++;
            lookup_id  = table_id;
            lookup_gap = cyc - last_hs_cyc;
         end
         if (table_invalidate) begin
            inv_cnt++;
            if (inv_q.size() == 0) fail("inv_unexpected", $sformatf("table_id %0h", table_id));
            else check("inv_id", table_id, inv_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic insert(input logic [IDW-1:0] id, input logic [PW-1:0] port);
      ref_map[id] = int'(port);
      ins_id   = id;
      ins_port = port;
      ins_req  = 1'b1;
      @(posedge clock); #1;
      ins_req  = 1'b0;
   endtask

   task automatic drive_beat(input logic [IDW-1:0] id, input logic [DW-1:0] d, input logic last);
      s_id    = id;
      s_data  = d;
      s_last  = last;
      s_valid = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clock);
         if (s_ready && !reset) begin
            @(posedge clock); #1;
            return;
         end
      end
      fail("beat_timeout", $sformatf("id %0h not accepted in 200 cycles", id));
      s_valid = 1'b0;
   endtask

   // Reference: a burst whose ID is in the table goes entirely to the stored
   // port and retires the entry; otherwise it is one orphan and yields nothing.
   task automatic send_burst(input logic [IDW-1:0] id, input int n, input logic [DW-1:0] base);
      int p;
      if (ref_map.exists(id)) begin
         p = ref_map[id];
         for (int i = 0; i < n; i++)
            exp_q.push_back({PW'(p), (i == n - 1), base + DW'(i)});
         inv_q.push_back(id);
         exp_inv++;
         ref_map.delete(id);
      end else begin
         exp_orph++;
         exp_orph_tot++;
      end
      burst_start_cyc = cyc;
      for (int i = 0; i < n; i++) drive_beat(id, base + DW'(i), (i == n - 1));
      s_valid = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int snap_inv, snap_orph, snap_drop, snap_mv1, snap_lk;
      logic [IDW-1:0] rid;
      logic [DW-1:0]  rbase;

      repeat (3) @(posedge clock);
      #1;
      check("rst_state", dbg_state, IDLE);
      check("rst_s_ready", s_ready, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_lookup", table_lookup, 0);
      check("rst_invalidate", table_invalidate, 0);
      check("rst_orphan", orphan, 0);
      check("rst_orphan_count", orphan_count, 0);
      check("rst_table_id", table_id, 0);
      reset = 1'b0;
      idle(2);

      // single-beat burst to port 1
      insert(16'h01ad, 1'b1);
      snap_inv = inv_cnt;
      send_burst(16'h01ad, 1, {4{32'hAAAA_AAAA}});
      check("t1_latency", first_mv_cyc - burst_start_cyc, 3);
      idle(2);
      check("t1_inv_count", inv_cnt - snap_inv, 1);
      check("t1_entry_gone", table_has(16'h01ad), 0);

      // 4-beat burst to port 0 under alternating ready
      insert(16'h018d, 1'b0);
      snap_inv = inv_cnt;
      snap_mv1 = mv1_cnt;
      rdy_mode = 1;
      send_burst(16'h018d, 4, {4{$urandom}});
      rdy_mode = 0;
      idle(2);
      check("t2_mvalid1_quiet", mv1_cnt - snap_mv1, 0);
      check("t2_inv_count", inv_cnt - snap_inv, 1);
      check("t2_sb_empty", exp_q.size(), 0);

      // orphan burst
      snap_inv  = inv_cnt;
      snap_orph = orphan_pulses;
      snap_drop = drop_hs;
      send_burst(16'h090d, 3, {4{$urandom}});
      idle(2);
      check("t3_orphan_pulse", orphan_pulses - snap_orph, 1);
      check("t3_dropped_beats", drop_hs - snap_drop, 3);
      check("t3_orphan_count", orphan_count, exp_orph);
      check("t3_no_inv", inv_cnt - snap_inv, 0);

      // back-to-back bursts to different ports
      insert(16'h01ad, 1'b1);
      insert(16'h01cd, 1'b0);
      snap_inv = inv_cnt;
      send_burst(16'h01ad, 2, {4{$urandom}});
      send_burst(16'h01cd, 2, {4{$urandom}});
      idle(2);
      check("t4_lookup_gap", lookup_gap, 2);
      check("t4_inv_count", inv_cnt - snap_inv, 2);
      check("t4_sb_empty", exp_q.size(), 0);

      // asynchronous reset in the middle of a burst
      insert(16'h0222, 1'b1);
      rbase = {4{$urandom}};
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, (i == 3), rbase + DW'(i)});
      inv_q.push_back(16'h0222);
      exp_inv++;
      ref_map.delete(16'h0222);
      drive_beat(16'h0222, rbase, 1'b0);
      drive_beat(16'h0222, rbase + DW'(1), 1'b0);
      s_data  = rbase + DW'(2);
      s_valid = 1'b1;
      #1 reset = 1'b1;
      #1;
      check("t5_rst_s_ready", s_ready, 0);
      check("t5_rst_m_valid", m_valid, 0);
      check("t5_rst_orphan_count", orphan_count, 0);
      exp_orph = 0;
      @(posedge clock); #1;
      reset = 1'b0;
      snap_lk = lookup_cnt;
      drive_beat(16'h0222, rbase + DW'(2), 1'b0);
      check("t5_relookup", lookup_cnt - snap_lk, 1);
      check("t5_relookup_id", lookup_id, 16'h0222);
      drive_beat(16'h0222, rbase + DW'(3), 1'b1);
      s_valid = 1'b0;
      idle(2);

      // randomized traffic
      rdy_mode = 2;
      for (int it = 0; it < 60; it++) begin
         rid = 16'h0300 + 16'($urandom_range(0, 5));
         if (!ref_map.exists(rid) && ($urandom_range(0, 1) == 1))
            insert(rid, PW'($urandom_range(0, NP - 1)));
         send_burst(rid, $urandom_range(1, 4), {$urandom, $urandom, $urandom, $urandom});
         idle($urandom_range(0, 2));
      end
      rdy_mode = 0;
      idle(5);

      check("final_inv_count", inv_cnt, exp_inv);
      check("final_orphan_count", orphan_count, exp_orph);
      check("final_orphan_pulses", orphan_pulses, exp_orph_tot);
      check("final_sb_empty", exp_q.size(), 0);
      check("final_inv_q_empty", inv_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
